// File: rtl/shift_sequencer_if.sv
// rtl/shift_sequencer_if.sv - command and result handshake bundle for the shift sequencer
interface shift_sequencer_if #(
    parameter int WIDTH = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [2:0]       cmd_amt;
    logic [WIDTH-1:0] cmd_data;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_carry;
    logic             res_zero;

    modport master (
        output cmd_valid, cmd_op, cmd_amt, cmd_data, res_ready,
        input  cmd_ready, res_valid, res_data, res_carry, res_zero
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_amt, cmd_data, res_ready,
        output cmd_ready, res_valid, res_data, res_carry, res_zero
    );
endinterface

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - command front-end and post-mask stage for the 8-bit rotate-right barrel
module shift_sequencer #(
    parameter int WIDTH   = 8,
    parameter int BRL_LAT = 1
) (
    input  logic             clk,
    input  logic             reset,
    shift_sequencer_if.slave bus,
    output logic             brl_load,
    output logic [2:0]       brl_sel,
    output logic [WIDTH-1:0] brl_data,
    input  logic [WIDTH-1:0] brl_result,
    output logic             busy
);
    localparam logic [2:0] OP_RR  = 3'b000;
    localparam logic [2:0] OP_RL  = 3'b001;
    localparam logic [2:0] OP_SRL = 3'b010;
    localparam logic [2:0] OP_SLL = 3'b011;
    localparam logic [2:0] OP_SRA = 3'b100;
    localparam logic [1:0] LAT_INIT = 2'(BRL_LAT);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             capture;
    logic [2:0]       op_q;
    logic [2:0]       amt_q;
    logic [1:0]       cnt;
    logic [2:0]       sel_c;
    logic [2:0]       neg_amt;
    logic [2:0]       right_idx;
    logic [WIDTH-1:0] mask_hi;
    logic [WIDTH-1:0] mask_lo;
    logic [WIDTH-1:0] masked;
    logic             carry_c;
    logic [WIDTH-1:0] res_data_q;
    logic             res_carry_q;
    logic             res_zero_q;

    // Control strobes decode straight from the state flop so they are glitch-free and reset to idle values
    assign bus.cmd_ready = (state == S_IDLE);
    assign brl_load      = (state == S_ISSUE);
    assign bus.res_valid = (state == S_DONE);
    assign busy          = (state != S_IDLE);
    assign bus.res_data  = res_data_q;
    assign bus.res_carry = res_carry_q;
    assign bus.res_zero  = res_zero_q;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; accept and capture are the two datapath load enables
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        capture   = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    accept    = 1'b1;
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT: begin
                if (cnt == 2'd1) begin
                    capture   = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.res_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Left rotates are done on the right-only barrel by rotating right by (8-n) mod 8
    always_comb begin
        sel_c = 3'd0;
        case (bus.cmd_op)
            OP_RR, OP_SRL, OP_SRA: sel_c = bus.cmd_amt;
            OP_RL, OP_SLL:         sel_c = 3'd0 - bus.cmd_amt;
            default:               sel_c = 3'd0;
        endcase
    end

    // Post-mask the rotated value and pick the last bit shifted out of the original operand
    always_comb begin
        neg_amt   = 3'd0 - amt_q;
        right_idx = amt_q - 3'd1;
        mask_hi   = ~({WIDTH{1'b1}} >> amt_q);
        mask_lo   = ~({WIDTH{1'b1}} << amt_q);
        masked    = brl_result;
        carry_c   = 1'b0;
        case (op_q)
            OP_RR: begin
                carry_c = (amt_q != 3'd0) && brl_data[right_idx];
            end
            OP_RL: begin
                carry_c = (amt_q != 3'd0) && brl_data[neg_amt];
            end
            OP_SRL: begin
                masked  = brl_result & ~mask_hi;
                carry_c = (amt_q != 3'd0) && brl_data[right_idx];
            end
            OP_SRA: begin
                masked  = brl_data[WIDTH-1] ? (brl_result | mask_hi) : (brl_result & ~mask_hi);
                carry_c = (amt_q != 3'd0) && brl_data[right_idx];
            end
            OP_SLL: begin
                masked  = brl_result & ~mask_lo;
                carry_c = (amt_q != 3'd0) && brl_data[neg_amt];
            end
            default: begin
                masked  = brl_result;
                carry_c = 1'b0;
            end
        endcase
    end

    // Command latch, barrel drive registers, latency counter and result registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            op_q        <= 3'd0;
            amt_q       <= 3'd0;
            brl_sel     <= 3'd0;
            brl_data    <= '0;
            cnt         <= 2'd0;
            res_data_q  <= '0;
            res_carry_q <= 1'b0;
            res_zero_q  <= 1'b0;
        end else begin
            if (accept) begin
                op_q     <= bus.cmd_op;
                amt_q    <= bus.cmd_amt;
                brl_data <= bus.cmd_data;
                brl_sel  <= sel_c;
            end
            if (state == S_ISSUE) begin
                cnt <= LAT_INIT;
            end else if (state == S_WAIT) begin
                cnt <= cnt - 2'd1;
            end
            if (capture) begin
                res_data_q  <= masked;
                res_carry_q <= carry_c;
                res_zero_q  <= (masked == '0);
            end
        end
    end
endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - directed table-driven bench for shift_sequencer
module tb_shift_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b0;

    shift_sequencer_if bus1();
    shift_sequencer_if bus3();

    logic       brl_load1, brl_load3;
    logic [2:0] brl_sel1, brl_sel3;
    logic [7:0] brl_data1, brl_data3;
    logic [7:0] brl_result1, brl_result3;
    logic       busy1, busy3;
    logic [7:0] b1_q;
    logic [7:0] b3_s0, b3_s1, b3_s2;

    int n_checks = 0;
    int n_fail = 0;

    shift_sequencer #(.WIDTH(8), .BRL_LAT(1)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1.slave),
        .brl_load(brl_load1), .brl_sel(brl_sel1), .brl_data(brl_data1),
        .brl_result(brl_result1), .busy(busy1)
    );

    shift_sequencer #(.WIDTH(8), .BRL_LAT(3)) dut3 (
        .clk(clk), .reset(reset), .bus(bus3.slave),
        .brl_load(brl_load3), .brl_sel(brl_sel3), .brl_data(brl_data3),
        .brl_result(brl_result3), .busy(busy3)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rotr(input logic [7:0] d, input logic [2:0] s);
        logic [15:0] t;
        t = {d, d} >> s;
        return t[7:0];
    endfunction

    // Barrel models: capture on the load edge, result appears BRL_LAT edges later
    always @(posedge clk) begin
        if (brl_load1) b1_q <= rotr(brl_data1, brl_sel1);
        if (brl_load3) b3_s0 <= rotr(brl_data3, brl_sel3);
        b3_s1 <= b3_s0;
        b3_s2 <= b3_s1;
    end
    assign brl_result1 = b1_q;
    assign brl_result3 = b3_s2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0] op;
        logic [2:0] amt;
        logic [7:0] data;
        logic [2:0] sel;
        logic [7:0] res;
        logic       c;
        logic       z;
    } vec_t;

    vec_t vt[18];

    // One full transaction on dut1 with fixed BRL_LAT=1 timing checks
    task automatic run_vec(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("v%0d", idx);
        @(negedge clk);
        chk({tag, "_cmd_ready"}, 32'(bus1.cmd_ready), 32'd1);
        bus1.cmd_valid = 1'b1;
        bus1.cmd_op    = v.op;
        bus1.cmd_amt   = v.amt;
        bus1.cmd_data  = v.data;
        @(negedge clk);
        bus1.cmd_valid = 1'b0;
        chk({tag, "_issue_load"}, 32'(brl_load1), 32'd1);
        chk({tag, "_issue_sel"}, 32'(brl_sel1), 32'(v.sel));
        chk({tag, "_issue_data"}, 32'(brl_data1), 32'(v.data));
        chk({tag, "_issue_ready"}, 32'(bus1.cmd_ready), 32'd0);
        chk({tag, "_issue_valid"}, 32'(bus1.res_valid), 32'd0);
        @(negedge clk);
        chk({tag, "_wait_load"}, 32'(brl_load1), 32'd0);
        chk({tag, "_wait_valid"}, 32'(bus1.res_valid), 32'd0);
        chk({tag, "_wait_sel"}, 32'(brl_sel1), 32'(v.sel));
        @(negedge clk);
        chk({tag, "_done_valid"}, 32'(bus1.res_valid), 32'd1);
        chk({tag, "_res_data"}, 32'(bus1.res_data), 32'(v.res));
        chk({tag, "_res_carry"}, 32'(bus1.res_carry), 32'(v.c));
        chk({tag, "_res_zero"}, 32'(bus1.res_zero), 32'(v.z));
        chk({tag, "_done_load"}, 32'(brl_load1), 32'd0);
        @(negedge clk);
        chk({tag, "_retire_valid"}, 32'(bus1.res_valid), 32'd0);
        chk({tag, "_retire_busy"}, 32'(busy1), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        logic seen;
        vt[0]  = '{3'b000, 3'd3, 8'hB1, 3'd3, 8'h36, 1'b0, 1'b0};
        vt[1]  = '{3'b001, 3'd1, 8'h81, 3'd7, 8'h03, 1'b1, 1'b0};
        vt[2]  = '{3'b010, 3'd4, 8'h81, 3'd4, 8'h08, 1'b0, 1'b0};
        vt[3]  = '{3'b100, 3'd4, 8'h81, 3'd4, 8'hF8, 1'b0, 1'b0};
        vt[4]  = '{3'b011, 3'd1, 8'h80, 3'd7, 8'h00, 1'b1, 1'b1};
        vt[5]  = '{3'b011, 3'd4, 8'h0F, 3'd4, 8'hF0, 1'b0, 1'b0};
        vt[6]  = '{3'b000, 3'd0, 8'hA5, 3'd0, 8'hA5, 1'b0, 1'b0};
        vt[7]  = '{3'b001, 3'd0, 8'hA5, 3'd0, 8'hA5, 1'b0, 1'b0};
        vt[8]  = '{3'b010, 3'd0, 8'hA5, 3'd0, 8'hA5, 1'b0, 1'b0};
        vt[9]  = '{3'b011, 3'd0, 8'hA5, 3'd0, 8'hA5, 1'b0, 1'b0};
        vt[10] = '{3'b100, 3'd0, 8'hA5, 3'd0, 8'hA5, 1'b0, 1'b0};
        vt[11] = '{3'b111, 3'd5, 8'h5A, 3'd0, 8'h5A, 1'b0, 1'b0};
        vt[12] = '{3'b101, 3'd2, 8'h5A, 3'd0, 8'h5A, 1'b0, 1'b0};
        vt[13] = '{3'b000, 3'd2, 8'h00, 3'd2, 8'h00, 1'b0, 1'b1};
        vt[14] = '{3'b100, 3'd7, 8'h80, 3'd7, 8'hFF, 1'b0, 1'b0};
        vt[15] = '{3'b010, 3'd7, 8'h80, 3'd7, 8'h01, 1'b0, 1'b0};
        vt[16] = '{3'b000, 3'd1, 8'h01, 3'd1, 8'h80, 1'b1, 1'b0};
        vt[17] = '{3'b011, 3'd7, 8'h03, 3'd1, 8'h80, 1'b1, 1'b0};

        bus1.cmd_valid = 1'b0; bus1.cmd_op = 3'd0; bus1.cmd_amt = 3'd0; bus1.cmd_data = 8'h00;
        bus1.res_ready = 1'b1;
        bus3.cmd_valid = 1'b0; bus3.cmd_op = 3'd0; bus3.cmd_amt = 3'd0; bus3.cmd_data = 8'h00;
        bus3.res_ready = 1'b1;
        reset = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_brl_load", 32'(brl_load1), 32'd0);
        chk("rst_brl_sel", 32'(brl_sel1), 32'd0);
        chk("rst_brl_data", 32'(brl_data1), 32'd0);
        chk("rst_res_valid", 32'(bus1.res_valid), 32'd0);
        chk("rst_res_data", 32'(bus1.res_data), 32'd0);
        chk("rst_res_carry", 32'(bus1.res_carry), 32'd0);
        chk("rst_res_zero", 32'(bus1.res_zero), 32'd0);
        chk("rst_cmd_ready", 32'(bus1.cmd_ready), 32'd1);
        chk("rst_busy", 32'(busy1), 32'd0);
        reset = 1'b1;

        // Table of single transactions
        for (int i = 0; i < 18; i++) begin
            run_vec(vt[i], i);
        end

        // Backpressure with a second command waiting
        bus1.res_ready = 1'b0;
        @(negedge clk);
        bus1.cmd_valid = 1'b1; bus1.cmd_op = 3'b000; bus1.cmd_amt = 3'd3; bus1.cmd_data = 8'hB1;
        @(negedge clk);
        bus1.cmd_op = 3'b011; bus1.cmd_amt = 3'd4; bus1.cmd_data = 8'h0F;
        @(negedge clk);
        @(negedge clk);
        chk("bp_first_valid", 32'(bus1.res_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_hold_valid%0d", i), 32'(bus1.res_valid), 32'd1);
            chk($sformatf("bp_hold_data%0d", i), 32'(bus1.res_data), 32'h36);
            chk($sformatf("bp_hold_ready%0d", i), 32'(bus1.cmd_ready), 32'd0);
            @(negedge clk);
        end
        bus1.res_ready = 1'b1;
        @(negedge clk);
        chk("bp_retire_valid", 32'(bus1.res_valid), 32'd0);
        chk("bp_retire_ready", 32'(bus1.cmd_ready), 32'd1);
        @(negedge clk);
        bus1.cmd_valid = 1'b0;
        chk("bp_second_load", 32'(brl_load1), 32'd1);
        chk("bp_second_sel", 32'(brl_sel1), 32'd4);
        chk("bp_second_data", 32'(brl_data1), 32'h0F);
        @(negedge clk);
        @(negedge clk);
        chk("bp_second_valid", 32'(bus1.res_valid), 32'd1);
        chk("bp_second_res", 32'(bus1.res_data), 32'hF0);
        chk("bp_second_carry", 32'(bus1.res_carry), 32'd0);
        @(negedge clk);

        // BRL_LAT=3: result 5 cycles after accept
        bus3.cmd_valid = 1'b1; bus3.cmd_op = 3'b100; bus3.cmd_amt = 3'd4; bus3.cmd_data = 8'h81;
        k = 0;
        seen = 1'b0;
        while (!seen && k < 20) begin
            @(negedge clk);
            bus3.cmd_valid = 1'b0;
            k++;
            if (bus3.res_valid) seen = 1'b1;
        end
        chk("lat3_cycles", 32'(k), 32'd5);
        chk("lat3_res", 32'(bus3.res_data), 32'hF8);
        chk("lat3_carry", 32'(bus3.res_carry), 32'd0);

        // Reset during WAIT abandons the command
        @(negedge clk);
        bus1.cmd_valid = 1'b1; bus1.cmd_op = 3'b000; bus1.cmd_amt = 3'd3; bus1.cmd_data = 8'hB1;
        @(negedge clk);
        bus1.cmd_valid = 1'b0;
        @(negedge clk);
        chk("rw_in_wait_busy", 32'(busy1), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("rw_idle_busy", 32'(busy1), 32'd0);
        chk("rw_idle_ready", 32'(bus1.cmd_ready), 32'd1);
        chk("rw_load", 32'(brl_load1), 32'd0);
        chk("rw_valid", 32'(bus1.res_valid), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus1.res_valid || brl_load1) seen = 1'b1;
        end
        chk("rw_no_result", 32'(seen), 32'd0);
        run_vec(vt[3], 100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
